// File: rtl/ysyx_22040632_mul_seq.sv
// ---------------------------------------------------------------------------
// ysyx_22040632_mul_seq
//   Iterative radix-2 shift-add multiplier for the EXU ALU extension.
//   It takes one operand pair, works on one multiplier bit per cycle
//   (64 cycles, or 32 for mulw), and returns the full product with a
//   one-cycle o_out_valid pulse. The pipeline can cancel an in-flight
//   multiply with i_flush.
//
// Ports
//   i_clk          core clock, all state changes on the rising edge
//   i_rst_n        synchronous active-low reset
//   i_mul_valid    operand pair offered this cycle
//   i_flush        cancel any in-flight multiply
//   i_mulw         1: 32-bit multiply of operand bits [31:0]
//   i_mul_signed   11 s*s, 10 s*u, 00 and 01 u*u
//   i_multiplicand operand A
//   i_multiplier   operand B
//   o_mul_ready    block can take an operand pair
//   o_out_valid    result valid, one-cycle pulse
//   o_result_hi    product bits [127:64] (mulw: sext of bits [63:32])
//   o_result_lo    product bits [63:0]   (mulw: sext of bits [31:0])
//   o_state        current FSM state, for debug and checkers
//
// Handshake: an operand pair is taken on a rising edge where
// i_mul_valid & o_mul_ready & ~i_flush are all high. o_mul_ready depends
// only on the state, never on i_mul_valid. Once taken, the requester may
// drop i_mul_valid on the next cycle. While o_mul_ready is low, i_mul_valid
// is ignored.
// ---------------------------------------------------------------------------
module ysyx_22040632_mul_seq #(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_mul_valid,
    input  logic            i_flush,
    input  logic            i_mulw,
    input  logic [1:0]      i_mul_signed,
    input  logic [XLEN-1:0] i_multiplicand,
    input  logic [XLEN-1:0] i_multiplier,
    output logic            o_mul_ready,
    output logic            o_out_valid,
    output logic [XLEN-1:0] o_result_hi,
    output logic [XLEN-1:0] o_result_lo,
    output logic [1:0]      o_state
);
    localparam int PLEN = 2 * XLEN;
    localparam int CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_D  = CW'(XLEN - 1);
    localparam logic [CW-1:0] LAST_W  = CW'(WLEN - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [PLEN-1:0] r_acc;
    logic [PLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic            r_neg;
    logic            r_mulw;
    logic            r_out_valid;
    logic [XLEN-1:0] r_res_hi;
    logic [XLEN-1:0] r_res_lo;

    // Operand sign and magnitude. For mulw, sign-extend the low word
    // before negating, so that 2^31 stays exact as an unsigned magnitude.
    logic            w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_op, w_b_op, w_a_mag, w_b_mag;

    always_comb begin
        w_a_neg = i_mul_signed[1] &
                  (i_mulw ? i_multiplicand[WLEN-1] : i_multiplicand[XLEN-1]);
        w_b_neg = (i_mul_signed == 2'b11) &
                  (i_mulw ? i_multiplier[WLEN-1] : i_multiplier[XLEN-1]);
        w_a_op  = i_mulw ? {{(XLEN-WLEN){w_a_neg}}, i_multiplicand[WLEN-1:0]}
                         : i_multiplicand;
        w_b_op  = i_mulw ? {{(XLEN-WLEN){w_b_neg}}, i_multiplier[WLEN-1:0]}
                         : i_multiplier;
        w_a_mag = w_a_neg ? -w_a_op : w_a_op;
        w_b_mag = w_b_neg ? -w_b_op : w_b_op;
    end

    // One shift-add step. The final step's sum feeds the result registers
    // directly, so the last multiplier bit is included in the result.
    logic [PLEN-1:0] w_acc_next, w_prod;
    logic [XLEN-1:0] w_res_hi, w_res_lo;
    logic            w_last;

    always_comb begin
        w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_prod     = r_neg ? -w_acc_next : w_acc_next;
        if (r_mulw) begin
            w_res_lo = {{(XLEN-WLEN){w_prod[WLEN-1]}},   w_prod[WLEN-1:0]};
            w_res_hi = {{(XLEN-WLEN){w_prod[2*WLEN-1]}}, w_prod[2*WLEN-1:WLEN]};
        end else begin
            w_res_lo = w_prod[XLEN-1:0];
            w_res_hi = w_prod[PLEN-1:XLEN];
        end
        w_last = (r_cnt == (r_mulw ? LAST_W : LAST_D));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_neg       <= 1'b0;
            r_mulw      <= 1'b0;
            r_out_valid <= 1'b0;
            r_res_hi    <= '0;
            r_res_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (i_mul_valid && !i_flush) begin
                        r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_mulw   <= i_mulw;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + CNT_ONE;
                        if (w_last) begin
                            r_res_hi    <= w_res_hi;
                            r_res_lo    <= w_res_lo;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // The pulse is already on the output; flush or not,
                    // the block goes back to idle.
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mul_ready = (r_state == S_IDLE);
    assign o_out_valid = r_out_valid;
    assign o_result_hi = r_res_hi;
    assign o_result_lo = r_res_lo;
    assign o_state     = r_state;

endmodule

// File: tb/tb_ysyx_22040632_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040632_mul_seq
//   Self-checking bench for ysyx_22040632_mul_seq. The driver pushes the
//   expected {hi, lo} and the expected out_valid cycle into queues. A
//   monitor pops and compares them whenever out_valid is seen.
//   The reference model is a plain signed 130-bit multiply.
// ---------------------------------------------------------------------------
module tb_ysyx_22040632_mul_seq;
    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mul_valid, flush, mulw;
    logic [1:0]  mul_signed;
    logic [63:0] mcand, mplier;
    logic        mul_ready, out_valid;
    logic [63:0] res_hi, res_lo;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [127:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [127:0] last_res;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_22040632_mul_seq dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_mul_valid    (mul_valid),
        .i_flush        (flush),
        .i_mulw         (mulw),
        .i_mul_signed   (mul_signed),
        .i_multiplicand (mcand),
        .i_multiplier   (mplier),
        .o_mul_ready    (mul_ready),
        .o_out_valid    (out_valid),
        .o_result_hi    (res_hi),
        .o_result_lo    (res_lo),
        .o_state        (dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] sgn, input logic w);
        logic signed [129:0] sa, sb, p;
        logic a_s, b_s;
        a_s = sgn[1];
        b_s = (sgn == 2'b11);
        if (w) begin
            sa = a_s ? {{98{a[31]}}, a[31:0]} : {98'b0, a[31:0]};
            sb = b_s ? {{98{b[31]}}, b[31:0]} : {98'b0, b[31:0]};
        end else begin
            sa = a_s ? {{66{a[63]}}, a} : {66'b0, a};
            sb = b_s ? {{66{b[63]}}, b} : {66'b0, b};
        end
        p = sa * sb;
        if (w) return {{32{p[63]}}, p[63:32], {32{p[31]}}, p[31:0]};
        return p[127:0];
    endfunction

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 6))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h0000_0000_8000_0000;
            4:       return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mul_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 128'(mul_ready), 128'(1));
    endtask

    // Offer an operand pair and return the cycle index right after acceptance.
    task automatic accept(input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] sgn, input logic w,
                          output int e, output bit ok);
        e = 0;
        wait_ready(ok);
        if (!ok) return;
        check("hold_result", {res_hi, res_lo}, last_res);
        mcand      = a;
        mplier     = b;
        mul_signed = sgn;
        mulw       = w;
        mul_valid  = 1'b1;
        @(posedge clk);
        #1;
        e          = cyc;
        mul_valid  = 1'b0;
        // Operands must already be latched; scramble the bus.
        mcand      = {$urandom, $urandom};
        mplier     = {$urandom, $urandom};
        mul_signed = 2'($urandom_range(0, 3));
        mulw       = 1'($urandom_range(0, 1));
    endtask

    task automatic do_mul(input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] sgn, input logic w, input bit chk_ready);
        int e, n;
        bit ok;
        accept(a, b, sgn, w, e, ok);
        if (!ok) return;
        n        = w ? 32 : 64;
        last_res = ref_mul(a, b, sgn, w);
        exp_q.push_back(last_res);
        exp_cyc_q.push_back(e + n);
        if (chk_ready) begin
            for (int k = 0; k <= n; k++) begin
                @(negedge clk);
                check("ready_low_busy", 128'(mul_ready), 128'(0));
            end
            @(negedge clk);
            check("ready_back", 128'(mul_ready), 128'(1));
        end
    endtask

    task automatic expect_const(input string name, input logic [63:0] hi, input logic [63:0] lo);
        bit ok;
        wait_ready(ok);
        check(name, {res_hi, res_lo}, {hi, lo});
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 128'(out_valid), 128'(0));
                end else begin
                    check("result", {res_hi, res_lo}, exp_q.pop_front());
                    check("latency", 128'(cyc), 128'(exp_cyc_q.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int  e;
        bit  ok;
        rst_n      = 1'b0;
        mul_valid  = 1'b0;
        flush      = 1'b0;
        mulw       = 1'b0;
        mul_signed = 2'b00;
        mcand      = '0;
        mplier     = '0;
        last_res   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", 128'(mul_ready), 128'(1));
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_result", {res_hi, res_lo}, 128'(0));
        check("reset_state", 128'(dbg_state), 128'(0));

        // Directed cases with known products.
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 2'b00, 1'b0, 1'b1);
        expect_const("unsigned_64", 64'h1, 64'hFFFF_FFFF_FFFF_FFFE);
        do_mul(-64'sd3, 64'd5, 2'b11, 1'b0, 1'b0);
        expect_const("signed_64", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1);
        do_mul(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0, 1'b0);
        expect_const("signed_min", 64'h4000_0000_0000_0000, 64'h0);
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 1'b0);
        expect_const("signed_unsigned", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        do_mul(64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 2'b11, 1'b1, 1'b1);
        expect_const("mulw_signed", 64'h0, 64'hFFFF_FFFF_FFFF_FFFE);
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 1'b0);
        expect_const("sign01_as_unsigned", 64'hFFFF_FFFF_FFFF_FFFE, 64'h1);
        do_mul(64'h0, 64'h1234_5678_9ABC_DEF0, 2'b11, 1'b0, 1'b0);
        expect_const("zero_operand", 64'h0, 64'h0);
        do_mul(64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 2'b11, 1'b1, 1'b0);

        // Randomized operands, signedness and width.
        for (int i = 0; i < 40; i++) begin
            do_mul(rnd_op(), rnd_op(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Flush in cycle T+10 of a running multiply.
        accept({$urandom, $urandom}, {$urandom, $urandom}, 2'b11, 1'b0, e, ok);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_ready", 128'(mul_ready), 128'(1));
        check("flush_hold", {res_hi, res_lo}, last_res);

        // Flush together with mul_valid in idle: must not be accepted.
        wait_ready(ok);
        mcand     = 64'h7;
        mplier    = 64'h9;
        mul_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        mul_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        check("flush_idle_ready", 128'(mul_ready), 128'(1));
        check("flush_idle_state", 128'(dbg_state), 128'(0));

        // Flush in the DONE cycle: the pulse still appears.
        accept(64'h1234, 64'h5678, 2'b00, 1'b1, e, ok);
        last_res = ref_mul(64'h1234, 64'h5678, 2'b00, 1'b1);
        exp_q.push_back(last_res);
        exp_cyc_q.push_back(e + 32);
        repeat (33) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_done_ready", 128'(mul_ready), 128'(1));
        check("flush_done_out_valid", 128'(out_valid), 128'(0));

        // Reset in cycle T+20 of a running multiply.
        do_mul(64'h3, 64'h7, 2'b00, 1'b0, 1'b0);
        accept({$urandom, $urandom}, {$urandom, $urandom}, 2'b10, 1'b0, e, ok);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_res = '0;
        @(negedge clk);
        check("rst_mid_ready", 128'(mul_ready), 128'(1));
        check("rst_mid_out_valid", 128'(out_valid), 128'(0));
        check("rst_mid_result", {res_hi, res_lo}, 128'(0));

        // Recovery after reset.
        do_mul(64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 2'b11, 1'b0, 1'b0);
        expect_const("after_reset", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF00);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_22040632_mul_seq.md
Name: ysyx_22040632_mul_seq

Overview:
- Iterative radix-2 shift-add multiplier: the mulunit-side responder of the CPU↔multiplier interface.
- Sits in the EXU ALU extension.
- Accepts one operand pair via a valid/ready handshake and computes the full 128-bit product over 32 or 64 cycles.
- Presents result_hi/result_lo with a one-cycle out_valid pulse; supports flush (cancel) from the pipeline.

Parameters:
- XLEN, 64, operand width; product width is 2*XLEN.
- WLEN, 32, operand width used when mulw=1.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset.
- mul_valid  input  1  operands valid this cycle.
- flush  input  1  cancel any in-flight multiply.
- mulw  input  1  1 = 32-bit multiply using operands[31:0].
- mul_signed  input  2  11 signed×signed; 10 signed multiplicand × unsigned multiplier; 00 unsigned×unsigned; 01 treated as 00.
- multiplicand  input  64  operand A.
- multiplier  input  64  operand B.
- mul_ready  output  1  high when the block can accept operands.
- out_valid  output  1  result valid (one-cycle pulse).
- result_hi  output  64  product bits [127:64] (see mulw rule).
- result_lo  output  64  product bits [63:0] (see mulw rule).

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at posedge):
  - state←IDLE, out_valid←0, result_hi/lo←0, counter and accumulator cleared.
  - Reset overrides flush and mul_valid.
  - Reset mid-operation abandons the computation with no out_valid.
- mul_ready = (state==IDLE), purely combinational from state.
- Acceptance: mul_valid & mul_ready & ~flush at a posedge (cycle T).
  - Latch |A| and |B| per mul_signed: A negative iff mul_signed[1] & A msb; B negative iff mul_signed==11 & B msb.
  - Latch neg = signA ^ signB; latch mulw.
  - Magnitude of the most-negative value (2^63, or 2^31 for mulw) is taken as unsigned and is exact.
  - When mulw=1, only bits [31:0] of each operand are used; msb means bit 31.
- States:
  - IDLE → BUSY on acceptance.
  - BUSY: one multiplier bit per cycle. If B bit is 1, add |A| to the accumulator; shift. Counter runs N = 64 (mulw=0) or 32 (mulw=1).
  - On the N-th BUSY cycle, write the result registers (two's-complement negated if neg) → DONE.
  - DONE: out_valid=1 for exactly this cycle → IDLE.
- Latency: accept at T; out_valid high during cycle T+N+1; mul_ready high again at T+N+2.
- Result registers:
  - Hold their value from the DONE write until the next DONE write or reset.
  - Flush does not clear them.
- mulw result (p = 64-bit product of the 32-bit operands):
  - result_lo = sext(p[31:0]).
  - result_hi = sext(p[63:32]).
- flush:
  - In BUSY or DONE: next state IDLE; out_valid is 0 from the next cycle; no result write.
  - Flush in the DONE cycle does not suppress that cycle's out_valid, because out_valid is registered state.
  - In IDLE with mul_valid: the request is not accepted.
- mul_valid while not ready: ignored. The CPU must hold it until ready, or drop it the cycle after acceptance.
- Zero operand: still takes full N cycles; result 0, hi 0.
- Accumulator width: 128 bits; no overflow possible for unsigned magnitudes.

Test Plan:
- Unsigned 64-bit: A=0xFFFF_FFFF_FFFF_FFFF, B=2, signed=00, accept T → out_valid only at T+65; hi=0x1, lo=0xFFFF_FFFF_FFFF_FFFE; mul_ready=0 T+1..T+65, 1 at T+66.
- Signed: A=-3, B=5, signed=11 → hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFF1.
- Signed edge: A=B=0x8000_0000_0000_0000, signed=11 → hi=0x4000_0000_0000_0000, lo=0.
- Signed×unsigned: A=-1, B=0xFFFF_FFFF_FFFF_FFFF, signed=10 → hi=0xFFFF_FFFF_FFFF_FFFF, lo=0x1.
- mulw: A=0xDEAD_BEEF_7FFF_FFFF, B=0x1234_5678_0000_0002, signed=11, mulw=1 → out_valid at T+33; lo=0xFFFF_FFFF_FFFF_FFFE, hi=0.
- Flush/reset: flush at T+10 → no out_valid, mul_ready=1 at T+11, result regs unchanged.
  - Separate run: rst_n=0 for one cycle at T+20 → IDLE next cycle, out_valid=0, hi=lo=0.
  - Flush with mul_valid in IDLE → not accepted.
